// File: rtl/bp_lce_mem_port_arbiter.sv
// Shares one single-ported cache memory between the cache pipeline (priority) and the LCE.
// A wait counter forces an LCE grant after bounded starvation; a lock lets the LCE hold the port.
module bp_lce_mem_port_arbiter #(
   parameter int unsigned pkt_width_p         = 32,
   parameter int unsigned timeout_max_limit_p = 4,
   parameter int unsigned stat_cnt_width_p    = 16
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,

   input  logic                        cache_v_i,
   input  logic [pkt_width_p-1:0]      cache_pkt_i,
   input  logic                        cache_read_i,
   output logic                        cache_ready_o,
   output logic                        cache_data_v_o,

   input  logic                        lce_v_i,
   input  logic [pkt_width_p-1:0]      lce_pkt_i,
   input  logic                        lce_read_i,
   input  logic                        lce_lock_i,
   output logic                        lce_yumi_o,
   output logic                        lce_data_v_o,

   output logic                        mem_v_o,
   output logic [pkt_width_p-1:0]      mem_pkt_o,
   input  logic                        mem_ready_i,

   output logic [stat_cnt_width_p-1:0] starve_cnt_o
);

   localparam int unsigned wait_cnt_width_lp =
      ($clog2(timeout_max_limit_p + 1) > 0) ? $clog2(timeout_max_limit_p + 1) : 1;
   localparam logic [wait_cnt_width_lp-1:0] wait_max_lp =
      wait_cnt_width_lp'(timeout_max_limit_p);

   typedef enum logic [0:0] {e_open = 1'b0, e_locked = 1'b1} state_e;

   state_e                         state_r, state_n;
   logic [wait_cnt_width_lp-1:0]   wait_cnt_r, wait_cnt_n;
   logic                           starved;
   logic                           cache_grant;
   logic                           starve_inc;

   // State register
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) state_r <= e_open;
      else            state_r <= state_n;
   end

   // Lock acquire/release happens only on a consumed LCE beat
   always_comb begin
      state_n = state_r;
      case (state_r)
         e_open:   if (lce_yumi_o &&  lce_lock_i) state_n = e_locked;
         e_locked: if (lce_yumi_o && !lce_lock_i) state_n = e_open;
         default:  state_n = e_open;
      endcase
   end

   // Grant logic: cache first unless locked or the LCE has waited too long
   always_comb begin
      starved       = (wait_cnt_r == wait_max_lp);
      cache_ready_o = mem_ready_i && (state_r == e_open) && !starved;
      cache_grant   = cache_v_i && cache_ready_o;
      lce_yumi_o    = lce_v_i && mem_ready_i && !cache_grant;
      mem_v_o       = cache_grant || lce_yumi_o;
      mem_pkt_o     = cache_grant ? cache_pkt_i : lce_pkt_i;

      wait_cnt_n = wait_cnt_r;
      if (!lce_v_i || lce_yumi_o)   wait_cnt_n = '0;
      else if (!starved)            wait_cnt_n = wait_cnt_r + wait_cnt_width_lp'(1);

      // Rising edge of starvation, registered in the same cycle wait_cnt reaches the limit
      starve_inc = (wait_cnt_n == wait_max_lp) && !starved;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wait_cnt_r     <= '0;
         cache_data_v_o <= 1'b0;
         lce_data_v_o   <= 1'b0;
         starve_cnt_o   <= '0;
      end else begin
         wait_cnt_r     <= wait_cnt_n;
         cache_data_v_o <= cache_grant && cache_read_i;
         lce_data_v_o   <= lce_yumi_o && lce_read_i;
         if (starve_inc && (starve_cnt_o != '1))
            starve_cnt_o <= starve_cnt_o + stat_cnt_width_p'(1);
      end
   end

endmodule

// File: tb/tb_bp_lce_mem_port_arbiter.sv
// Directed bench for bp_lce_mem_port_arbiter: inputs change 1ns after posedge, outputs sampled at negedge.
module tb_bp_lce_mem_port_arbiter;

   localparam int unsigned pkt_w = 16;

   logic             clk, reset_n;
   logic             cache_v, cache_read, cache_ready, cache_data_v;
   logic [pkt_w-1:0] cache_pkt, lce_pkt, mem_pkt;
   logic             lce_v, lce_read, lce_lock, lce_yumi, lce_data_v;
   logic             mem_v, mem_ready;
   logic [15:0]      starve_cnt;

   int total = 0;
   int bad   = 0;

   bp_lce_mem_port_arbiter #(
      .pkt_width_p(pkt_w), .timeout_max_limit_p(4), .stat_cnt_width_p(16)
   ) dut (
      .clk_i(clk), .reset_n_i(reset_n),
      .cache_v_i(cache_v), .cache_pkt_i(cache_pkt), .cache_read_i(cache_read),
      .cache_ready_o(cache_ready), .cache_data_v_o(cache_data_v),
      .lce_v_i(lce_v), .lce_pkt_i(lce_pkt), .lce_read_i(lce_read), .lce_lock_i(lce_lock),
      .lce_yumi_o(lce_yumi), .lce_data_v_o(lce_data_v),
      .mem_v_o(mem_v), .mem_pkt_o(mem_pkt), .mem_ready_i(mem_ready),
      .starve_cnt_o(starve_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cache_v = 0; cache_read = 0; lce_v = 0; lce_read = 0; lce_lock = 0;
   endtask

   task automatic test_reset();
      reset_n = 0; mem_ready = 1; idle_inputs();
      cache_pkt = 16'hC000; lce_pkt = 16'hA000;
      #12;
      total++; if (cache_ready !== 1'b1) begin bad++; $display("FAIL reset_cache_ready got=%b exp=1", cache_ready); end
      total++; if (lce_yumi !== 1'b0) begin bad++; $display("FAIL reset_lce_yumi got=%b exp=0", lce_yumi); end
      total++; if ({cache_data_v, lce_data_v} !== 2'b00) begin bad++; $display("FAIL reset_data_v got=%b exp=00", {cache_data_v, lce_data_v}); end
      total++; if (starve_cnt !== 16'd0) begin bad++; $display("FAIL reset_starve got=%0d exp=0", starve_cnt); end
      next_cycle();
      reset_n = 1;
      next_cycle();
   endtask

   task automatic test_contention();
      logic exp_c;
      cache_v = 1; lce_v = 1; cache_pkt = 16'hC001; lce_pkt = 16'hA001;
      for (int cyc = 0; cyc < 6; cyc++) begin
         exp_c = (cyc != 4);
         @(negedge clk);
         total++; if (cache_ready !== exp_c) begin bad++; $display("FAIL cont_cache_ready cyc=%0d got=%b exp=%b", cyc, cache_ready, exp_c); end
         total++; if (lce_yumi !== !exp_c) begin bad++; $display("FAIL cont_lce_yumi cyc=%0d got=%b exp=%b", cyc, lce_yumi, !exp_c); end
         total++; if (mem_v !== 1'b1 || mem_pkt !== (exp_c ? 16'hC001 : 16'hA001))
            begin bad++; $display("FAIL cont_mem cyc=%0d got=%b/%h exp=1/%h", cyc, mem_v, mem_pkt, exp_c ? 16'hC001 : 16'hA001); end
         total++; if (starve_cnt !== ((cyc >= 4) ? 16'd1 : 16'd0)) begin bad++; $display("FAIL cont_starve cyc=%0d got=%0d exp=%0d", cyc, starve_cnt, (cyc >= 4) ? 1 : 0); end
         next_cycle();
      end
      idle_inputs();
      next_cycle();
   endtask

   task automatic test_lock();
      logic [3:0] locks;
      locks = 4'b0111;
      lce_pkt = 16'hA100;
      for (int i = 0; i < 4; i++) begin
         lce_v = 1; lce_lock = locks[i]; cache_v = (i > 0); cache_pkt = 16'hC100;
         lce_pkt = 16'hA100 + 16'(i);
         @(negedge clk);
         total++; if (lce_yumi !== 1'b1) begin bad++; $display("FAIL lock_yumi beat=%0d got=%b exp=1", i, lce_yumi); end
         total++; if (cache_ready !== (i == 0)) begin bad++; $display("FAIL lock_cache_ready beat=%0d got=%b exp=%b", i, cache_ready, i == 0); end
         total++; if (mem_pkt !== 16'hA100 + 16'(i)) begin bad++; $display("FAIL lock_pkt beat=%0d got=%h exp=%h", i, mem_pkt, 16'hA100 + 16'(i)); end
         next_cycle();
      end
      lce_v = 0; lce_lock = 0; cache_v = 1;
      @(negedge clk);
      total++; if (cache_ready !== 1'b1 || mem_v !== 1'b1 || mem_pkt !== 16'hC100)
         begin bad++; $display("FAIL lock_release got=%b/%b/%h exp=1/1/c100", cache_ready, mem_v, mem_pkt); end
      total++; if (starve_cnt !== 16'd1) begin bad++; $display("FAIL lock_starve got=%0d exp=1", starve_cnt); end
      next_cycle();
      idle_inputs();
      next_cycle();
   endtask

   task automatic test_read_return();
      cache_v = 1; cache_read = 1; cache_pkt = 16'hC200;
      @(negedge clk);
      total++; if (mem_v !== 1'b1 || mem_pkt !== 16'hC200) begin bad++; $display("FAIL rd_cache_grant got=%b/%h exp=1/c200", mem_v, mem_pkt); end
      next_cycle();
      cache_v = 0; cache_read = 0; lce_v = 1; lce_read = 1; lce_pkt = 16'hA200;
      @(negedge clk);
      total++; if ({cache_data_v, lce_data_v} !== 2'b10) begin bad++; $display("FAIL rd_n1_data_v got=%b exp=10", {cache_data_v, lce_data_v}); end
      total++; if (lce_yumi !== 1'b1) begin bad++; $display("FAIL rd_lce_yumi got=%b exp=1", lce_yumi); end
      next_cycle();
      idle_inputs();
      @(negedge clk);
      total++; if ({cache_data_v, lce_data_v} !== 2'b01) begin bad++; $display("FAIL rd_n2_data_v got=%b exp=01", {cache_data_v, lce_data_v}); end
      next_cycle();
      @(negedge clk);
      total++; if ({cache_data_v, lce_data_v} !== 2'b00) begin bad++; $display("FAIL rd_n3_data_v got=%b exp=00", {cache_data_v, lce_data_v}); end
      next_cycle();
   endtask

   task automatic test_mem_not_ready();
      mem_ready = 0; lce_v = 1; lce_pkt = 16'hA300; cache_pkt = 16'hC300;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         total++; if (mem_v !== 1'b0 || lce_yumi !== 1'b0 || cache_ready !== 1'b0)
            begin bad++; $display("FAIL nr_idle cyc=%0d got=%b%b%b exp=000", i, mem_v, lce_yumi, cache_ready); end
         total++; if (starve_cnt !== ((i >= 4) ? 16'd2 : 16'd1)) begin bad++; $display("FAIL nr_starve cyc=%0d got=%0d exp=%0d", i, starve_cnt, (i >= 4) ? 2 : 1); end
         next_cycle();
      end
      mem_ready = 1; cache_v = 1;
      @(negedge clk);
      total++; if (lce_yumi !== 1'b1 || cache_ready !== 1'b0 || mem_pkt !== 16'hA300)
         begin bad++; $display("FAIL nr_lce_first got=%b/%b/%h exp=1/0/a300", lce_yumi, cache_ready, mem_pkt); end
      total++; if (starve_cnt !== 16'd2) begin bad++; $display("FAIL nr_starve_hold got=%0d exp=2", starve_cnt); end
      next_cycle();
      lce_v = 0;
      @(negedge clk);
      total++; if (cache_ready !== 1'b1 || mem_pkt !== 16'hC300) begin bad++; $display("FAIL nr_cache_after got=%b/%h exp=1/c300", cache_ready, mem_pkt); end
      next_cycle();
      idle_inputs();
      next_cycle();
   endtask

   task automatic test_reset_mid_lock();
      lce_v = 1; lce_lock = 1; lce_read = 1; lce_pkt = 16'hA400;
      next_cycle();
      lce_v = 0; lce_lock = 0; lce_read = 0;
      total++; if (lce_data_v !== 1'b1 || cache_ready !== 1'b0)
         begin bad++; $display("FAIL rl_pre got=%b/%b exp=1/0", lce_data_v, cache_ready); end
      #2;
      reset_n = 0;
      #1;
      total++; if ({cache_data_v, lce_data_v} !== 2'b00) begin bad++; $display("FAIL rl_data_v got=%b exp=00", {cache_data_v, lce_data_v}); end
      total++; if (cache_ready !== 1'b1) begin bad++; $display("FAIL rl_open got=%b exp=1", cache_ready); end
      total++; if (starve_cnt !== 16'd0) begin bad++; $display("FAIL rl_starve got=%0d exp=0", starve_cnt); end
      next_cycle();
      reset_n = 1; cache_v = 1; cache_pkt = 16'hC400;
      @(negedge clk);
      total++; if (mem_v !== 1'b1 || mem_pkt !== 16'hC400) begin bad++; $display("FAIL rl_cache_after got=%b/%h exp=1/c400", mem_v, mem_pkt); end
      next_cycle();
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_contention();
      test_lock();
      test_read_return();
      test_mem_not_ready();
      test_reset_mid_lock();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
